// File: rtl/regfile_bank.sv
// ----------------------------------------------------------------------------
// regfile_bank
//   Storage stage of the register file: NREG x DATA_W flop registers. It has
//   one synchronous write port and a sequenced bulk-clear engine. Every
//   register is presented in parallel on a packed bus that feeds the read-port
//   multiplexers directly. Register ZERO_REG (XZR) always reads zero.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   RegWrite       write enable for the write port
//   WriteRegister  destination register index (5 bits)
//   WriteData      data to write, stored unmodified at full width
//   clr_start      one-cycle request to start a bulk clear of all registers
//   busy           high while the clear sequence runs (32 cycles)
//   wr_drop        one-cycle pulse per write discarded because busy was high
//   regs           parallel view of all registers, regs[k] is register k
// ----------------------------------------------------------------------------
module regfile_bank #(
  parameter int DATA_W   = 64,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         RegWrite,
  input  logic [4:0]                   WriteRegister,
  input  logic [DATA_W-1:0]            WriteData,
  input  logic                         clr_start,
  output logic                         busy,
  output logic                         wr_drop,
  output logic [NREG-1:0][DATA_W-1:0]  regs
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [4:0]                    ptr_q, ptr_d;
  logic                          busy_q, busy_d;
  logic                          wr_drop_q, wr_drop_d;
  logic [NREG-1:0][DATA_W-1:0]   regs_q, regs_d;

  logic [NREG-1:0]               wr_en;
  logic                          wr_req;

  // A write aimed at XZR is not a request at all: it neither stores nor
  // counts as a dropped write.
  assign wr_req = RegWrite && (WriteRegister != 5'(ZERO_REG));

  // 5:32 one-hot write decoder, gated off while the clear engine owns the array.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    wr_en = '0;
    if (wr_req && !busy_q) begin
      wr_en[WriteRegister] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    wr_drop_d = wr_req && busy_q;

    for (int k = 0; k < NREG; k++) begin
      regs_d[k] = wr_en[k] ? WriteData : regs_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        // A write in the same cycle as clr_start still lands (busy is low);
        // the sweep zeroes it again when the pointer gets there.
        if (clr_start) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
          ptr_d   = 5'd0;
        end
      end
      ST_CLEAR: begin
        // clr_start is ignored here: the sweep neither restarts nor extends.
        regs_d[ptr_q] = '0;
        ptr_d         = ptr_q + 5'd1;  // 31 -> 0 wrap on exit
        if (ptr_q == 5'(NREG - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase

    // XZR can never hold anything but zero, whatever the paths above did.
    regs_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the whole array is reset, not just the control state. Software
      // relies on a known all-zero file after reset, which also means this
      // array is built from resettable flops rather than a RAM macro.
      state_q   <= ST_IDLE;
      ptr_q     <= 5'd0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      regs_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge value of every other flop.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
      regs_q    <= regs_d;
    end
  end

  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;
  assign regs    = regs_q;

endmodule

// File: tb/tb_regfile_bank.sv
// ----------------------------------------------------------------------------
// tb_regfile_bank
//   Self-checking bench for regfile_bank: a vector table for single-cycle
//   writes, a scoreboard queue for write results, and hand-written sequences
//   for the clear engine, writes during a clear and reset during a clear.
// ----------------------------------------------------------------------------
module tb_regfile_bank;

  localparam int DATA_W = 64;
  localparam int NREG   = 32;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        RegWrite;
  logic [4:0]                  WriteRegister;
  logic [DATA_W-1:0]           WriteData;
  logic                        clr_start;
  logic                        busy;
  logic                        wr_drop;
  logic [NREG-1:0][DATA_W-1:0] regs;

  regfile_bank #(.DATA_W(DATA_W), .NREG(NREG), .ZERO_REG(31)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .clr_start     (clr_start),
    .busy          (busy),
    .wr_drop       (wr_drop),
    .regs          (regs)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] m_regs [NREG];

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] val;
    logic              drop;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string             name;
    logic              we;
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp_reg;
    logic              exp_drop;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: advance past the rising edge so outputs are sampled settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int idx, input logic [DATA_W-1:0] val,
                         input logic drop);
    sb_t e;
    e.idx  = idx;
    e.val  = val;
    e.drop = drop;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input string name);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", name);
    end else begin
      e = sb_q.pop_front();
      check({name, "_reg"}, regs[e.idx], e.val);
      check({name, "_drop"}, {63'd0, wr_drop}, {63'd0, e.drop});
    end
  endtask

  task automatic check_all(input string name);
    for (int k = 0; k < NREG; k++) begin
      check($sformatf("%s_r%0d", name, k), regs[k], m_regs[k]);
    end
  endtask

  initial begin
    int               busy_cnt;
    int               drops;
    logic             saw999;

    vecs[0] = '{"wr_r5",    1'b1, 5'd5,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[1] = '{"wr_xzr",   1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1'b0};
    vecs[2] = '{"hold_r5",  1'b0, 5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[3] = '{"wr_r0",    1'b1, 5'd0,  64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0};
    vecs[4] = '{"wr_r30",   1'b1, 5'd30, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0};

    for (int k = 0; k < NREG; k++) m_regs[k] = '0;

    // Reset state.
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0; clr_start = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_drop", {63'd0, wr_drop}, 64'd0);
    check_all("rst");

    // Table-driven single writes in IDLE.
    for (int i = 0; i < 5; i++) begin
      RegWrite      = vecs[i].we;
      WriteRegister = vecs[i].addr;
      WriteData     = vecs[i].data;
      sb_push(int'(vecs[i].addr), vecs[i].exp_reg, vecs[i].exp_drop);
      if (vecs[i].we && vecs[i].addr != 5'd31) m_regs[vecs[i].addr] = vecs[i].data;
      step();
      sb_pop_check(vecs[i].name);
    end
    RegWrite = 1'b0;
    check_all("table");

    // Full write sweep k*3+7 to every writable register.
    for (int k = 0; k < NREG - 1; k++) begin
      RegWrite      = 1'b1;
      WriteRegister = 5'(k);
      WriteData     = 64'(k * 3 + 7);
      m_regs[k]     = 64'(k * 3 + 7);
      sb_push(k, 64'(k * 3 + 7), 1'b0);
      step();
      sb_pop_check("sweep");
    end
    RegWrite = 1'b0;
    step();
    check_all("sweep_all");

    // Bulk clear, with an ignored clr_start re-pulse in the middle.
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    check("clr1_busy_rise", {63'd0, busy}, 64'd1);
    busy_cnt = busy ? 1 : 0;
    for (int j = 1; j <= 40 && busy; j++) begin
      clr_start = (j == 5);
      step();
      if (busy) busy_cnt++;
      if (j <= 32) check($sformatf("clr1_zero_r%0d", j - 1), regs[j - 1], 64'd0);
      if (j <= 30) check($sformatf("clr1_hold_r%0d", j), regs[j], m_regs[j]);
    end
    clr_start = 1'b0;
    check("clr1_busy_len", 64'(busy_cnt), 64'd32);
    for (int k = 0; k < NREG; k++) m_regs[k] = '0;
    check_all("clr1_end");

    // Simultaneous clr_start + write, then a dropped write at cycle 10.
    RegWrite = 1'b1; WriteRegister = 5'd20; WriteData = 64'hAAAA_5555_AAAA_5555;
    clr_start = 1'b1;
    step();
    RegWrite = 1'b0; clr_start = 1'b0;
    check("simul_write", regs[20], 64'hAAAA_5555_AAAA_5555);
    check("simul_busy", {63'd0, busy}, 64'd1);
    drops = 0; saw999 = 1'b0;
    for (int j = 1; j <= 40 && busy; j++) begin
      RegWrite = (j == 10); WriteRegister = 5'd20; WriteData = 64'd999;
      step();
      if (wr_drop) drops++;
      if (regs[20] == 64'd999) saw999 = 1'b1;
      if (j == 10) check("drop_pulse", {63'd0, wr_drop}, 64'd1);
      if (j == 11) check("drop_single", {63'd0, wr_drop}, 64'd0);
      if (j == 20) check("r20_before_ptr", regs[20], 64'hAAAA_5555_AAAA_5555);
      if (j == 21) check("r20_at_ptr", regs[20], 64'd0);
    end
    RegWrite = 1'b0;
    check("drop_count", 64'(drops), 64'd1);
    check("never_999", {63'd0, saw999}, 64'd0);
    check("r20_end", regs[20], 64'd0);
    check("clr2_done", {63'd0, busy}, 64'd0);

    // Reset mid-clear, with back-to-back dropped writes just before it.
    RegWrite = 1'b1; WriteRegister = 5'd3;  WriteData = 64'd7; step();
    WriteRegister = 5'd30; WriteData = 64'd5; step();
    RegWrite = 1'b0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      RegWrite = (j == 13 || j == 14); WriteRegister = 5'd9; WriteData = 64'(j);
      step();
      if (j == 13) check("b2b_drop_a", {63'd0, wr_drop}, 64'd1);
      if (j == 14) check("b2b_drop_b", {63'd0, wr_drop}, 64'd1);
    end
    RegWrite = 1'b0;
    check("pre_rst_r30", regs[30], 64'd5);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_drop", {63'd0, wr_drop}, 64'd0);
    check_all("midrst");

    // Write accepted right after reset.
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'd42;
    m_regs[3] = 64'd42;
    sb_push(3, 64'd42, 1'b0);
    step();
    sb_pop_check("post_rst_wr");
    check("post_rst_busy", {63'd0, busy}, 64'd0);

    // The pointer restarts at 0 after the abandoned sweep.
    WriteRegister = 5'd0; WriteData = 64'd11;
    step();
    RegWrite = 1'b0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    step();
    check("ptr_restart_r0", regs[0], 64'd0);
    check("ptr_restart_r3", regs[3], 64'd42);
    for (int j = 0; j < 40 && busy; j++) step();
    check("final_idle", {63'd0, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Storage stage of the register file: 32 x 64-bit registers, one synchronous write port, and a sequenced bulk-clear engine.
- Presents every register in parallel on a packed 32x64 bus.
- That bus feeds the 32:1 read-port multiplexers directly.
- Register 31 is hardwired to zero (XZR).

Parameters:
- DATA_W, 64, register width in bits.
- NREG, 32, number of registers; fixed at 32 (address is 5 bits).
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  5  destination register index.
- WriteData  input  DATA_W  data to write.
- clr_start  input  1  one-cycle request to start a bulk clear of all registers.
- busy  output  1  high while the clear sequence runs.
- wr_drop  output  1  one-cycle pulse when a requested write is discarded because busy is high.
- regs  output  [NREG-1:0][DATA_W-1:0]  parallel view of all registers; regs[k] is register k.

Behaviour:
- Reset: on a rising clk edge with reset=1:
  - all registers, including ZERO_REG, are set to 0;
  - busy=0, wr_drop=0, clear pointer=0, FSM=IDLE.
  - reset overrides every other input, including a clear already in progress (the sequence is abandoned).
- Register outputs:
  - regs is driven directly from the flops, with no output muxing or bypass.
  - A write is visible on regs the cycle after the edge that captures it (latency 1).
- ZERO_REG: regs[31] reads 0 at all times. Writes addressed to 31 are silently ignored and do not pulse wr_drop.
- Write decode:
  - A 5:32 one-hot decoder, gated by RegWrite and by !busy, drives per-register enables.
  - A register whose enable is low holds its value.
  - At most one register changes per cycle through the write port.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_start=1. busy rises on the next edge, and the pointer is 0 on entry.
  - CLEAR, each cycle:
    - register[ptr] is set to 0 and ptr increments;
    - after ptr=31 is processed, the FSM returns to IDLE and busy falls.
    - CLEAR lasts exactly 32 cycles (ptr 31 is a no-op clear of the zero register).
  - clr_start while in CLEAR is ignored; the sequence does not restart or extend.
- Writes during CLEAR:
  - A RegWrite=1 with WriteRegister != 31 is discarded.
  - wr_drop=1 on the next cycle, for one cycle per dropped write. Back-to-back dropped writes give back-to-back pulses.
- Simultaneous events in IDLE:
  - clr_start and RegWrite in the same cycle: the write is performed (busy is still 0), and CLEAR begins the next cycle.
  - That register is therefore zeroed again when the pointer reaches it.
- Pointer wrap: the pointer is 5 bits and returns to 0 on exit from CLEAR. No other wrap is visible.
- Width rules: WriteData is stored unmodified at full DATA_W. No sign or zero extension is performed.

Test Plan:
- Reset then write: assert reset 1 cycle, then write WriteRegister=5, WriteData=64'h0123_4567_89AB_CDEF. Required: regs[5] equals that value the following cycle; all other regs stay 0.
- Zero register: write WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF. Required: regs[31]=0 and wr_drop stays 0.
- Full write sweep: write k*3+7 to each k=0..30 on consecutive cycles. Required: each regs[k] equals k*3+7; none overwrites a neighbour.
- Bulk clear:
  - Preload regs[0..30] with nonzero values, then pulse clr_start. Required: busy is high for exactly 32 cycles.
  - regs[k] reads 0 starting k+1 cycles after busy rises, while regs[k+1..30] still hold their prior values.
- Write during clear: at cycle 10 of CLEAR, write WriteRegister=20, data=64'd999. Required: wr_drop pulses once, regs[20] is never 999, and it ends at 0.
- Reset mid-clear: assert reset at cycle 15 of CLEAR. Required: busy=0 and all regs=0 the next cycle. A write of 64'd42 to reg 3 one cycle later is accepted.
